// File: rtl/touch_adc_pkg.sv
// touch_adc_pkg: shared FSM states, command layout and frame constants for the touch ADC scanner
package touch_adc_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  localparam int CMD_START   = 7;
  localparam int CMD_ADDR_HI = 6;
  localparam int CMD_ADDR_LO = 4;
  localparam int FRAME_OFS   = 12;
  localparam int BUSY_EDGE   = 9;
  function automatic logic [7:0] cmd_byte(input logic [2:0] addr);
    logic [7:0] c;
    c = '0;
    c[CMD_START] = 1'b1;
    c[CMD_ADDR_HI:CMD_ADDR_LO] = addr;
    return c;
  endfunction
endpackage

// File: rtl/touch_sclk_gen.sv
// touch_sclk_gen: divides cclk into touch_clk with one-cycle strobes marking each edge
module touch_sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic cclk,
  input  logic rstb,
  input  logic run,
  output logic touch_clk,
  output logic rise,
  output logic fall,
  output logic tick
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div;
  assign tick = div == DW'(CLK_DIV - 1);
  // half-period divider; clock parks low and divider restarts whenever run drops
  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) begin
      div       <= '0;
      touch_clk <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      div       <= run && !tick ? div + 1'b1 : '0;
      touch_clk <= run && (tick ? !touch_clk : touch_clk);
      rise      <= run && tick && !touch_clk;
      fall      <= run && tick && touch_clk;
    end
endmodule

// File: rtl/touch_adc_scanner.sv
// touch_adc_scanner: cycles serial touch ADC channels, averages conversions and rejects frames without busy
module touch_adc_scanner
  import touch_adc_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int NUM_CH = 3,
  parameter int RES_BITS = 12,
  parameter int AVG_LOG2 = 4,
  parameter logic [3*NUM_CH-1:0] CH_ADDRS = {3'b011, 3'b001, 3'b101}
) (
  input  logic                       cclk,
  input  logic                       rstb,
  input  logic                       enable,
  input  logic                       start,
  input  logic                       touch_busy,
  input  logic                       data_in,
  output logic                       touch_clk,
  output logic                       data_out,
  output logic                       touch_csb,
  output logic [NUM_CH*RES_BITS-1:0] samples,
  output logic                       sample_valid,
  output logic [2:0]                 sample_ch,
  output logic                       scan_done,
  output logic                       busy_err
);
  localparam int FRAME = RES_BITS + FRAME_OFS;
  localparam int ACC_W = RES_BITS + AVG_LOG2;
  localparam int EW    = $clog2(FRAME + 1);
  localparam int GW    = $clog2(2 * CLK_DIV);
  localparam int CW    = AVG_LOG2 + 1;
  state_t state, state_nx;
  logic run, tick, rise, fall, fin, gap_end, more, setup_go, new_scan, last_ch, avg_full, scan_end;
  logic in_scan, pend, busy_ok;
  logic [EW-1:0] edge_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0] ch;
  logic [7:0] cmd, cmd_sr;
  logic [RES_BITS-1:0] shreg;
  logic [ACC_W-1:0] acc, sum;
  logic [CW-1:0] cnt;
  assign cmd      = cmd_byte(CH_ADDRS[3*ch +: 3]);
  assign sum      = acc + ACC_W'(shreg);
  assign gap_end  = state == GAP && gap_cnt == GW'(2 * CLK_DIV - 1);
  assign more     = in_scan || enable || pend;
  assign fin      = state == SHIFT && state_nx == GAP;
  assign run      = (state == SETUP || state == SHIFT) && state_nx != GAP;
  assign setup_go = state_nx == SETUP && state != SETUP;
  assign new_scan = setup_go && (state == IDLE || !in_scan);
  assign last_ch  = ch == 3'(NUM_CH - 1);
  assign avg_full = cnt == CW'(2 ** AVG_LOG2 - 1);
  assign scan_end = fin && busy_ok && avg_full && last_ch;
  touch_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .cclk(cclk), .rstb(rstb), .run(run),
    .touch_clk(touch_clk), .rise(rise), .fall(fall), .tick(tick)
  );
  // state register
  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) state <= IDLE;
    else state <= state_nx;
  // next state: frame ends on the half-period boundary after the last falling edge
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable || start ? SETUP : IDLE;
      SETUP:   state_nx = tick ? SHIFT : SETUP;
      SHIFT:   state_nx = tick && !touch_clk && edge_cnt == EW'(FRAME) ? GAP : SHIFT;
      GAP:     state_nx = gap_end ? (more ? SETUP : IDLE) : GAP;
      default: state_nx = IDLE;
    endcase
  end
  // frame datapath: command shift-out, busy/data capture, averaging and result write-back
  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) begin
      touch_csb    <= 1'b1;
      data_out     <= 1'b0;
      samples      <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      scan_done    <= 1'b0;
      busy_err     <= 1'b0;
      edge_cnt     <= '0;
      gap_cnt      <= '0;
      cmd_sr       <= '0;
      shreg        <= '0;
      busy_ok      <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      ch           <= '0;
      in_scan      <= 1'b0;
      pend         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      busy_err     <= 1'b0;
      touch_csb    <= !(state_nx == SETUP || state_nx == SHIFT);
      gap_cnt      <= state == GAP && state_nx == GAP ? gap_cnt + 1'b1 : '0;
      pend         <= (start && state != IDLE) || (pend && !(gap_end && !in_scan));
      in_scan      <= new_scan || (in_scan && !scan_end);
      if (setup_go) begin
        edge_cnt <= '0;
        cmd_sr   <= cmd;
        data_out <= cmd[CMD_START];
      end else begin
        if (rise) edge_cnt <= edge_cnt + 1'b1;
        if (fall) begin
          data_out <= cmd_sr[CMD_START-1];
          cmd_sr   <= cmd_sr << 1;
        end
      end
      if (rise && edge_cnt == EW'(BUSY_EDGE - 1)) busy_ok <= touch_busy;
      if (rise && edge_cnt >= EW'(BUSY_EDGE) && edge_cnt < EW'(BUSY_EDGE + RES_BITS))
        shreg <= {shreg[RES_BITS-2:0], data_in};
      if (fin) begin
        if (!busy_ok) busy_err <= 1'b1;
        else if (avg_full) begin
          samples[RES_BITS*ch +: RES_BITS] <= RES_BITS'(sum >> AVG_LOG2);
          sample_valid <= 1'b1;
          sample_ch    <= ch;
          scan_done    <= last_ch;
          acc          <= '0;
          cnt          <= '0;
          ch           <= last_ch ? '0 : ch + 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_touch_adc_scanner.sv
// tb_touch_adc_scanner: directed checks of two scanner instances (no averaging / 4x averaging) against an ADC model
module tb_touch_adc_scanner;
  logic cclk = 1'b0;
  logic rstb = 1'b0;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic [11:0] vtab [16];
  int bad_frame = -1;
  int total = 0;
  int bad = 0;
  always #5 cclk = ~cclk;
  for (genvar k = 0; k < 2; k++) begin : g
    logic tclk, dout, csb, din, tbusy, sv, sd, be, pclk, pcsb;
    logic [2:0] sc;
    logic [35:0] smp;
    logic [7:0] cmd_rx;
    logic [63:0] hist;
    logic [31:0] chs;
    logic [11:0] cur;
    int rises, frames, nv, nd, ne;
    assign cur = vtab[frames % 16];
    touch_adc_scanner #(.CLK_DIV(2), .NUM_CH(3), .RES_BITS(12), .AVG_LOG2(2 * k)) u (
      .cclk(cclk), .rstb(rstb), .enable(enable), .start(start),
      .touch_busy(tbusy), .data_in(din),
      .touch_clk(tclk), .data_out(dout), .touch_csb(csb),
      .samples(smp), .sample_valid(sv), .sample_ch(sc), .scan_done(sd), .busy_err(be)
    );
    // ADC model and pulse recorder, evaluated away from the active clock edge
    always @(negedge cclk)
      if (!rstb) begin
        pclk <= 1'b0; pcsb <= 1'b1; din <= 1'b0; tbusy <= 1'b0;
        cmd_rx <= '0; hist <= '0; chs <= '0;
        rises <= 0; frames <= 0; nv <= 0; nd <= 0; ne <= 0;
      end else begin
        pclk <= tclk;
        pcsb <= csb;
        if (pcsb && !csb) begin rises <= 0; cmd_rx <= '0; end
        if (!pcsb && csb) begin
          hist <= {hist[55:0], cmd_rx};
          frames <= frames + 1;
          tbusy <= 1'b0;
          din <= 1'b0;
        end
        if (!pclk && tclk) begin
          rises <= rises + 1;
          if (rises < 8) cmd_rx <= {cmd_rx[6:0], dout};
        end
        if (pclk && !tclk) begin
          if (rises == 8) tbusy <= frames != bad_frame;
          if (rises >= 9 && rises <= 20) din <= cur[20-rises];
        end
        if (sv) begin nv <= nv + 1; chs <= {chs[27:0], 1'b0, sc}; end
        if (sd) nd <= nd + 1;
        if (be) ne <= ne + 1;
      end
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin @(negedge cclk); #1; end
  endtask
  task automatic do_reset();
    rstb = 1'b0;
    cyc(3);
    rstb = 1'b1;
    cyc(2);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) vtab[i] = 12'hA5C;
    do_reset();
    check("rst_csb", 64'(g[0].csb), 1);
    check("rst_tclk", 64'(g[0].tclk), 0);
    check("rst_dout", 64'(g[0].dout), 0);
    check("rst_samples", 64'(g[0].smp), 0);
    check("rst_valid", 64'(g[0].sv), 0);
    // command encoding and full single scan
    start = 1'b1;
    @(posedge cclk); #1;
    check("t1_csb_latency", 64'(g[0].csb), 0);
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 2000 && g[0].nd < 1; i++) cyc(1);
    check("t1_done_seen", 64'(g[0].nd >= 1), 1);
    check("t1_cmds", 64'(g[0].hist[23:0]), 64'hD090B0);
    check("t1_ch_seq", 64'(g[0].chs[11:0]), 64'h012);
    check("t1_samples", 64'(g[0].smp), 64'hA5CA5CA5C);
    check("t1_nvalid", 64'(g[0].nv), 3);
    cyc(300);
    check("t1_frames", 64'(g[0].frames), 3);
    check("t1_idle_csb", 64'(g[0].csb), 1);
    check("t1_no_err", 64'(g[0].ne), 0);
    // averaging over four conversions on the AVG_LOG2=2 instance
    vtab[0] = 12'd100; vtab[1] = 12'd101; vtab[2] = 12'd102; vtab[3] = 12'd104;
    do_reset();
    pulse_start();
    for (int i = 0; i < 2000 && g[1].nv < 1; i++) cyc(1);
    check("t2_valid_seen", 64'(g[1].nv), 1);
    check("t2_frames", 64'(g[1].frames), 4);
    check("t2_avg", 64'(g[1].smp[11:0]), 64'd101);
    check("t2_ch", 64'(g[1].chs[3:0]), 0);
    // busy rejection and retry on the same channel
    for (int i = 0; i < 16; i++) vtab[i] = 12'h3C7;
    bad_frame = 0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 2000 && g[0].nv < 1; i++) cyc(1);
    check("t3_valid_seen", 64'(g[0].nv), 1);
    check("t3_err", 64'(g[0].ne), 1);
    check("t3_frames", 64'(g[0].frames), 2);
    check("t3_cmds", 64'(g[0].hist[15:0]), 64'hD0D0);
    check("t3_sample", 64'(g[0].smp[11:0]), 64'h3C7);
    bad_frame = -1;
    // continuous mode, enable dropped during the 7th frame
    for (int i = 0; i < 16; i++) vtab[i] = 12'h100 + 12'(i);
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3000 && !(g[0].frames >= 6 && !g[0].csb); i++) cyc(1);
    check("t4_frame7_seen", 64'(g[0].frames), 6);
    enable = 1'b0;
    for (int i = 0; i < 2000 && g[0].frames < 9; i++) cyc(1);
    cyc(300);
    check("t4_frames", 64'(g[0].frames), 9);
    check("t4_nvalid", 64'(g[0].nv), 9);
    check("t4_ndone", 64'(g[0].nd), 3);
    check("t4_ch_seq", 64'(g[0].chs), 64'h12012012);
    check("t4_samples", 64'(g[0].smp), 64'h108107106);
    check("t4_idle_csb", 64'(g[0].csb), 1);
    // asynchronous reset in the middle of a frame
    pulse_start();
    for (int i = 0; i < 300 && g[0].rises < 12; i++) cyc(1);
    check("t5_edge12", 64'(g[0].rises), 12);
    check("t5_pre_csb", 64'(g[0].csb), 0);
    check("t5_pre_tclk", 64'(g[0].tclk), 1);
    rstb = 1'b0;
    #1;
    check("t5_async_csb", 64'(g[0].csb), 1);
    check("t5_async_tclk", 64'(g[0].tclk), 0);
    check("t5_async_samples", 64'(g[0].smp), 0);
    cyc(2);
    rstb = 1'b1;
    cyc(400);
    check("t5_quiet_frames", 64'(g[0].frames), 0);
    check("t5_quiet_valid", 64'(g[0].nv), 0);
    check("t5_samples", 64'(g[0].smp), 0);
    // start pulses while busy: exactly one extra scan
    pulse_start();
    cyc(20);
    pulse_start();
    cyc(100);
    pulse_start();
    for (int i = 0; i < 2000 && g[0].nd < 2; i++) cyc(1);
    cyc(400);
    check("t6_ndone", 64'(g[0].nd), 2);
    check("t6_frames", 64'(g[0].frames), 6);
    check("t6_nvalid", 64'(g[0].nv), 6);
    check("t6_idle_csb", 64'(g[0].csb), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
